// File: rtl/sap_control_sequencer.sv
// Microcoded control sequencer for the 8-bit bus computer: five-step T-counter,
// opcode decode into bus strobes, ALU flag latch and sticky halt.
module sap_control_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       cf_in,
  input  logic       zf_in,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ram_in,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       out_load,
  output logic       halted,
  output logic [2:0] step,
  output logic       cf,
  output logic       zf
);

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_LDA = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_STA = 4'h4;
  localparam logic [OP_W-1:0] OP_LDI = 4'h5;
  localparam logic [OP_W-1:0] OP_JMP = 4'h6;
  localparam logic [OP_W-1:0] OP_JC  = 4'h7;
  localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_e;

  typedef struct packed {
    logic pc_inc;
    logic pc_out;
    logic pc_load;
    logic mar_load;
    logic ram_out;
    logic ram_in;
    logic ir_load;
    logic ir_out;
    logic a_load;
    logic a_out;
    logic b_load;
    logic alu_out;
    logic alu_sub;
    logic out_load;
  } ctrl_t;

  tstate_e state_q, state_d;
  logic    halted_q, halted_d;
  logic    cf_q, cf_d;
  logic    zf_q, zf_d;
  ctrl_t   ctrl;

  // State register: T-counter, halt and latched flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= T0;
      halted_q <= 1'b0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      cf_q     <= cf_d;
      zf_q     <= zf_d;
    end
  end

  // Next-state: step advances unless halted; HLT parks the counter at T3.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    cf_d     = cf_q;
    zf_d     = zf_q;
    if (!halted_q) begin
      unique case (state_q)
        T0:      state_d = T1;
        T1:      state_d = T2;
        T2:      state_d = T3;
        T3:      state_d = T4;
        T4:      state_d = T0;
        default: state_d = T0;
      endcase
      if (state_q == T2 && opcode == OP_HLT) begin
        halted_d = 1'b1;
      end
    end
    if (ctrl.alu_out) begin
      cf_d = cf_in;
      zf_d = zf_in;
    end
  end

  // Control word decode; reset and halt force an all-zero word.
  always_comb begin
    ctrl = '0;
    if (rst_n && !halted_q) begin
      unique case (state_q)
        T0: begin
          ctrl.pc_out   = 1'b1;
          ctrl.mar_load = 1'b1;
        end
        T1: begin
          ctrl.ram_out = 1'b1;
          ctrl.ir_load = 1'b1;
          ctrl.pc_inc  = 1'b1;
        end
        T2: begin
          unique case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ctrl.ir_out   = 1'b1;
              ctrl.mar_load = 1'b1;
            end
            OP_LDI: begin
              ctrl.ir_out = 1'b1;
              ctrl.a_load = 1'b1;
            end
            OP_JMP: begin
              ctrl.ir_out  = 1'b1;
              ctrl.pc_load = 1'b1;
            end
            OP_JC: begin
              ctrl.ir_out  = 1'b1;
              ctrl.pc_load = cf_q;
            end
            OP_JZ: begin
              ctrl.ir_out  = 1'b1;
              ctrl.pc_load = zf_q;
            end
            OP_OUT: begin
              ctrl.a_out    = 1'b1;
              ctrl.out_load = 1'b1;
            end
            default: ctrl = '0;
          endcase
        end
        T3: begin
          unique case (opcode)
            OP_LDA: begin
              ctrl.ram_out = 1'b1;
              ctrl.a_load  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ctrl.ram_out = 1'b1;
              ctrl.b_load  = 1'b1;
            end
            OP_STA: begin
              ctrl.a_out  = 1'b1;
              ctrl.ram_in = 1'b1;
            end
            default: ctrl = '0;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            ctrl.alu_out = 1'b1;
            ctrl.a_load  = 1'b1;
            ctrl.alu_sub = (opcode == OP_SUB);
          end
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign pc_inc   = ctrl.pc_inc;
  assign pc_out   = ctrl.pc_out;
  assign pc_load  = ctrl.pc_load;
  assign mar_load = ctrl.mar_load;
  assign ram_out  = ctrl.ram_out;
  assign ram_in   = ctrl.ram_in;
  assign ir_load  = ctrl.ir_load;
  assign ir_out   = ctrl.ir_out;
  assign a_load   = ctrl.a_load;
  assign a_out    = ctrl.a_out;
  assign b_load   = ctrl.b_load;
  assign alu_out  = ctrl.alu_out;
  assign alu_sub  = ctrl.alu_sub;
  assign out_load = ctrl.out_load;

  assign halted = halted_q;
  assign step   = 3'(state_q);
  assign cf     = cf_q;
  assign zf     = zf_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Scoreboard bench for sap_control_sequencer: driver pushes per-cycle expected
// control words, a negedge monitor pops and compares against the DUT.
module tb_sap_control_sequencer;

  localparam logic [13:0] PC_INC   = 14'h2000;
  localparam logic [13:0] PC_OUT   = 14'h1000;
  localparam logic [13:0] PC_LOAD  = 14'h0800;
  localparam logic [13:0] MAR_LOAD = 14'h0400;
  localparam logic [13:0] RAM_OUT  = 14'h0200;
  localparam logic [13:0] RAM_IN   = 14'h0100;
  localparam logic [13:0] IR_LOAD  = 14'h0080;
  localparam logic [13:0] IR_OUT   = 14'h0040;
  localparam logic [13:0] A_LOAD   = 14'h0020;
  localparam logic [13:0] A_OUT    = 14'h0010;
  localparam logic [13:0] B_LOAD   = 14'h0008;
  localparam logic [13:0] ALU_OUT  = 14'h0004;
  localparam logic [13:0] ALU_SUB  = 14'h0002;
  localparam logic [13:0] OUT_LOAD = 14'h0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       cf_in = 1'b0;
  logic       zf_in = 1'b0;
  logic pc_inc, pc_out, pc_load, mar_load, ram_out, ram_in, ir_load, ir_out;
  logic a_load, a_out, b_load, alu_out, alu_sub, out_load, halted, cf, zf;
  logic [2:0] step;

  sap_control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .cf_in(cf_in), .zf_in(zf_in),
    .pc_inc(pc_inc), .pc_out(pc_out), .pc_load(pc_load), .mar_load(mar_load),
    .ram_out(ram_out), .ram_in(ram_in), .ir_load(ir_load), .ir_out(ir_out),
    .a_load(a_load), .a_out(a_out), .b_load(b_load), .alu_out(alu_out),
    .alu_sub(alu_sub), .out_load(out_load), .halted(halted), .step(step),
    .cf(cf), .zf(zf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] word;
    logic [2:0]  step;
    logic        cf;
    logic        zf;
    logic        halted;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Bench-side reference state
  int   m_step = 0;
  logic m_cf = 1'b0, m_zf = 1'b0, m_halt = 1'b0;

  function automatic logic [13:0] act_word();
    return {pc_inc, pc_out, pc_load, mar_load, ram_out, ram_in, ir_load,
            ir_out, a_load, a_out, b_load, alu_out, alu_sub, out_load};
  endfunction

  // Hand-written microcode table of the instruction set.
  function automatic logic [13:0] exp_word(logic [3:0] op, int t, logic fc, logic fz);
    logic [13:0] w;
    w = 14'h0;
    if (t == 0) w = PC_OUT | MAR_LOAD;
    else if (t == 1) w = RAM_OUT | IR_LOAD | PC_INC;
    else if (t == 2) begin
      case (op)
        4'h1, 4'h2, 4'h3, 4'h4: w = IR_OUT | MAR_LOAD;
        4'h5: w = IR_OUT | A_LOAD;
        4'h6: w = IR_OUT | PC_LOAD;
        4'h7: w = fc ? (IR_OUT | PC_LOAD) : IR_OUT;
        4'h8: w = fz ? (IR_OUT | PC_LOAD) : IR_OUT;
        4'hE: w = A_OUT | OUT_LOAD;
        default: w = 14'h0;
      endcase
    end else if (t == 3) begin
      case (op)
        4'h1: w = RAM_OUT | A_LOAD;
        4'h2, 4'h3: w = RAM_OUT | B_LOAD;
        4'h4: w = A_OUT | RAM_IN;
        default: w = 14'h0;
      endcase
    end else if (t == 4) begin
      if (op == 4'h2) w = ALU_OUT | A_LOAD;
      else if (op == 4'h3) w = ALU_OUT | A_LOAD | ALU_SUB;
    end
    return w;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus: drive inputs, push expectation, advance the model.
  task automatic drive_cycle(logic [3:0] op, logic cfi, logic zfi, logic rst);
    exp_t e;
    @(posedge clk);
    #1;
    opcode = op; cf_in = cfi; zf_in = zfi; rst_n = rst;
    if (!rst) begin
      m_step = 0; m_cf = 1'b0; m_zf = 1'b0; m_halt = 1'b0;
      e = '{word: 14'h0, step: 3'd0, cf: 1'b0, zf: 1'b0, halted: 1'b0};
      exp_q.push_back(e);
    end else begin
      e.word   = m_halt ? 14'h0 : exp_word(op, m_step, m_cf, m_zf);
      e.step   = 3'(m_step);
      e.cf     = m_cf;
      e.zf     = m_zf;
      e.halted = m_halt;
      exp_q.push_back(e);
      if (!m_halt) begin
        if ((e.word & ALU_OUT) != 14'h0) begin
          m_cf = cfi; m_zf = zfi;
        end
        if (op == 4'hF && m_step == 2) begin
          m_halt = 1'b1; m_step = 3;
        end else begin
          m_step = (m_step == 4) ? 0 : m_step + 1;
        end
      end
    end
  endtask

  // Full instruction; ALU flag inputs carry the wrong value outside T4.
  task automatic run_instr(logic [3:0] op, logic cf4, logic zf4);
    for (int t = 0; t < 5; t++) begin
      if (t == 4) drive_cycle(op, cf4, zf4, 1'b1);
      else        drive_cycle(op, ~cf4, ~zf4, 1'b1);
    end
  endtask

  // Monitor: every cycle presents a control word; compare at the negedge.
  initial begin
    exp_t e;
    int   drv;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ctrl_word", 32'(act_word()), 32'(e.word));
        check("step", 32'(step), 32'(e.step));
        check("flags_halt", 32'({cf, zf, halted}), 32'({e.cf, e.zf, e.halted}));
        drv = 32'(pc_out) + 32'(ram_out) + 32'(ir_out) + 32'(a_out) + 32'(alu_out);
        checks++;
        if (drv > 1) begin
          errors++;
          $display("FAIL bus_drivers: got %0d active expected at most 1 at %0t", drv, $time);
        end
      end
    end
  end

  initial begin
    // Reset, then 10 NOP cycles
    drive_cycle(4'h0, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'h0, 1'b0, 1'b0, 1'b0);
    run_instr(4'h0, 1'b1, 1'b1);
    run_instr(4'h0, 1'b1, 1'b1);

    // ADD latches cf=1 zf=0; LDI/STA/OUT leave flags alone; JC then takes
    run_instr(4'h2, 1'b1, 1'b0);
    run_instr(4'h5, 1'b0, 1'b1);
    run_instr(4'h4, 1'b0, 1'b1);
    run_instr(4'hE, 1'b0, 1'b1);
    run_instr(4'h7, 1'b0, 1'b0);
    run_instr(4'h8, 1'b0, 1'b0);

    // SUB zf=1 then JZ takes; SUB zf=0 then JZ/JC fall through
    run_instr(4'h3, 1'b1, 1'b1);
    run_instr(4'h8, 1'b0, 1'b0);
    run_instr(4'h3, 1'b0, 1'b0);
    run_instr(4'h8, 1'b1, 1'b1);
    run_instr(4'h7, 1'b1, 1'b1);
    run_instr(4'h6, 1'b0, 1'b0);

    // Every opcode below HLT
    for (int op = 0; op < 15; op++) run_instr(4'(op), op[0], op[1]);

    // HLT: T0..T2 then 20 frozen cycles at step 3
    for (int t = 0; t < 3; t++) drive_cycle(4'hF, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) drive_cycle(4'(i), 1'b1, 1'b1, 1'b1);
    drive_cycle(4'h0, 1'b0, 1'b0, 1'b0);
    drive_cycle(4'h0, 1'b0, 1'b0, 1'b0);

    // LDA aborted by reset during T3
    for (int t = 0; t < 4; t++) drive_cycle(4'h1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_strobes", 32'(act_word()), 32'h0);
    check("abort_step", 32'(step), 32'h0);
    m_step = 0; m_cf = 1'b0; m_zf = 1'b0; m_halt = 1'b0;
    drive_cycle(4'h1, 1'b0, 1'b0, 1'b0);
    run_instr(4'h1, 1'b0, 1'b0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
